// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_ctrl
// Brief   : UART receive control: 16x-baud prescaler, FWFT receive FIFO with
//           overrun/threshold interrupt. Macro UART_RX_ERRCNT_EN adds
//           saturating frame/parity error counters.
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx_ctrl #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [11:0]           divisor_i,
    output logic                  uart_cken_o,
    input  logic [7:0]            rx_byte_i,
    input  logic                  rx_en_i,
    input  logic                  frame_err_i,
    input  logic                  parity_err_i,
    input  logic                  rd_i,
    output logic [7:0]            rd_data_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [DEPTH_LOG2:0]   count_o,
    input  logic [DEPTH_LOG2-1:0] thresh_i,
    input  logic                  clr_i,
    output logic                  overrun_o,
`ifdef UART_RX_ERRCNT_EN
    output logic [7:0]            ferr_cnt_o,
    output logic [7:0]            perr_cnt_o,
`endif
    output logic                  irq_o
);

    localparam int                  C_DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] C_FULL    = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] C_CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] C_PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [11:0]           r_presc;
    logic                  r_cken;
    logic [7:0]            r_mem [C_DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_overrun;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [DEPTH_LOG2:0]   w_thresh;

    // Divisor is only sampled on reload, so a mid-count change cannot glitch.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_presc <= 12'd0;
            r_cken  <= 1'b0;
        end else if (r_presc == 12'd0) begin
            r_presc <= divisor_i;
            r_cken  <= 1'b1;
        end else begin
            r_presc <= r_presc - 12'd1;
            r_cken  <= 1'b0;
        end
    end

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == C_FULL);
    assign w_pop   = rd_i & ~w_empty;
    // A full FIFO still accepts a byte when the same cycle frees a slot.
    assign w_push  = rx_en_i & (~w_full | w_pop);
    assign w_drop  = rx_en_i & w_full & ~rd_i;

    always_ff @(posedge clk) begin
        if (w_push && !clr_i) begin
            r_mem[r_wr_ptr] <= rx_byte_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || clr_i) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            if (w_push && !w_pop)      r_count <= r_count + C_CNT_ONE;
            else if (w_pop && !w_push) r_count <= r_count - C_CNT_ONE;
            if (w_drop) r_overrun <= 1'b1;
        end
    end

    assign w_thresh = (thresh_i == '0) ? C_CNT_ONE : {1'b0, thresh_i};

`ifdef UART_RX_ERRCNT_EN
    logic [7:0] r_ferr_cnt;
    logic [7:0] r_perr_cnt;

    always_ff @(posedge clk) begin
        if (!resetn || clr_i) begin
            r_ferr_cnt <= 8'd0;
            r_perr_cnt <= 8'd0;
        end else begin
            if (frame_err_i && r_ferr_cnt != 8'hFF)  r_ferr_cnt <= r_ferr_cnt + 8'd1;
            if (parity_err_i && r_perr_cnt != 8'hFF) r_perr_cnt <= r_perr_cnt + 8'd1;
        end
    end

    assign ferr_cnt_o = r_ferr_cnt;
    assign perr_cnt_o = r_perr_cnt;
`else
    logic w_unused_err;
    assign w_unused_err = frame_err_i | parity_err_i;
`endif

    assign uart_cken_o = r_cken;
    assign rd_data_o   = r_mem[r_rd_ptr];
    assign empty_o     = w_empty;
    assign full_o      = w_full;
    assign count_o     = r_count;
    assign overrun_o   = r_overrun;
    assign irq_o       = r_overrun | (r_count >= w_thresh);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx_ctrl
// Brief   : Directed self-checking bench for uart_rx_ctrl with a byte
//           scoreboard queue; error counters checked when UART_RX_ERRCNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

    localparam int DL2   = 4;
    localparam int DEPTH = 1 << DL2;

    logic           clk = 1'b0;
    logic           resetn;
    logic [11:0]    divisor_i;
    logic           uart_cken_o;
    logic [7:0]     rx_byte_i;
    logic           rx_en_i;
    logic           frame_err_i;
    logic           parity_err_i;
    logic           rd_i;
    logic [7:0]     rd_data_o;
    logic           empty_o;
    logic           full_o;
    logic [DL2:0]   count_o;
    logic [DL2-1:0] thresh_i;
    logic           clr_i;
    logic           overrun_o;
    logic           irq_o;
`ifdef UART_RX_ERRCNT_EN
    logic [7:0]     ferr_cnt_o;
    logic [7:0]     perr_cnt_o;
`endif

    uart_rx_ctrl #(.DEPTH_LOG2(DL2)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .divisor_i    (divisor_i),
        .uart_cken_o  (uart_cken_o),
        .rx_byte_i    (rx_byte_i),
        .rx_en_i      (rx_en_i),
        .frame_err_i  (frame_err_i),
        .parity_err_i (parity_err_i),
        .rd_i         (rd_i),
        .rd_data_o    (rd_data_o),
        .empty_o      (empty_o),
        .full_o       (full_o),
        .count_o      (count_o),
        .thresh_i     (thresh_i),
        .clr_i        (clr_i),
        .overrun_o    (overrun_o),
`ifdef UART_RX_ERRCNT_EN
        .ferr_cnt_o   (ferr_cnt_o),
        .perr_cnt_o   (perr_cnt_o),
`endif
        .irq_o        (irq_o)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] mq[$];
    logic       m_ov = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic status(input string tag);
        int thr;
        thr = (thresh_i == '0) ? 1 : int'(thresh_i);
        chk({tag, ".count"},   32'(count_o),   32'(mq.size()));
        chk({tag, ".empty"},   32'(empty_o),   32'(mq.size() == 0));
        chk({tag, ".full"},    32'(full_o),    32'(mq.size() == DEPTH));
        chk({tag, ".overrun"}, 32'(overrun_o), 32'(m_ov));
        chk({tag, ".irq"},     32'(irq_o),     32'(m_ov || (mq.size() >= thr)));
    endtask

    task automatic push(input logic [7:0] b);
        rx_byte_i = b;
        rx_en_i   = 1'b1;
        tick();
        rx_en_i   = 1'b0;
        if (mq.size() < DEPTH) mq.push_back(b);
        else                   m_ov = 1'b1;
    endtask

    task automatic pop(input string tag);
        if (mq.size() > 0) chk({tag, ".data"}, 32'(rd_data_o), 32'(mq[0]));
        rd_i = 1'b1;
        tick();
        rd_i = 1'b0;
        if (mq.size() > 0) mq.delete(0);
    endtask

    task automatic pushpop(input logic [7:0] b, input string tag);
        if (mq.size() > 0) chk({tag, ".data"}, 32'(rd_data_o), 32'(mq[0]));
        rx_byte_i = b;
        rx_en_i   = 1'b1;
        rd_i      = 1'b1;
        tick();
        rx_en_i   = 1'b0;
        rd_i      = 1'b0;
        if (mq.size() > 0) mq.delete(0);
        mq.push_back(b);
    endtask

    task automatic clear();
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        mq.delete();
        m_ov = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        resetn = 1'b0;
        tick();
        mq.delete();
        m_ov = 1'b0;
        chk({tag, ".cken"}, 32'(uart_cken_o), 32'd0);
        status(tag);
        resetn = 1'b1;
    endtask

    // Cycles until the next cken pulse, bounded so a dead prescaler still ends.
    task automatic wait_ck(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!uart_cken_o && n < 100);
    endtask

    initial begin
        int n;
        resetn       = 1'b0;
        divisor_i    = 12'd2;
        rx_byte_i    = 8'h00;
        rx_en_i      = 1'b0;
        frame_err_i  = 1'b0;
        parity_err_i = 1'b0;
        rd_i         = 1'b0;
        thresh_i     = 4'd4;
        clr_i        = 1'b0;
        tick();
        do_reset("reset");

        // Prescaler: period 3, then a mid-count change to 5 takes effect after reload
        wait_ck(n);
        wait_ck(n);  chk("presc.div2", 32'(n), 32'd3);
        divisor_i = 12'd5;
        wait_ck(n);  chk("presc.old_period", 32'(n), 32'd3);
        wait_ck(n);  chk("presc.div5", 32'(n), 32'd6);
        divisor_i = 12'd0;
        wait_ck(n);  chk("presc.tail5", 32'(n), 32'd6);
        wait_ck(n);  chk("presc.div0", 32'(n), 32'd1);
        divisor_i = 12'd2;

        // Ordered FWFT reads
        push(8'h11); push(8'h22); push(8'h33);
        status("fifo3");
        pop("rd1"); pop("rd2"); pop("rd3");
        status("drained");

        // Threshold interrupt
        push(8'hA1); push(8'hA2); push(8'hA3);
        status("thr3");
        push(8'hA4);
        status("thr4");
        pop("thr_pop");
        status("thr_after_pop");
        while (mq.size() > 0) pop("thr_drain");

        // Overflow: 17th byte dropped, overrun sticky until clear
        for (int i = 0; i < DEPTH + 1; i++) push(8'h40 + 8'(i));
        status("overflow");
        for (int i = 0; i < DEPTH; i++) pop("ovf_drain");
        status("ovf_empty");
        clear();
        status("ovf_clr");

        // Full with simultaneous push and pop: no overrun, new byte last
        for (int i = 0; i < DEPTH; i++) push(8'h80 + 8'(i));
        pushpop(8'hEE, "full_pp");
        status("full_pp");
        for (int i = 0; i < DEPTH; i++) pop("full_pp_drain");
        status("full_pp_empty");

        // Empty corner cases
        rd_i = 1'b1; tick(); rd_i = 1'b0;
        status("empty_rd");
        pushpop(8'h5C, "empty_pp");
        status("empty_pp");
        pop("empty_pp_rd");

        // Clear beats a simultaneous push; error strobes never push
        push(8'h01); push(8'h02);
        rx_byte_i = 8'h03; rx_en_i = 1'b1;
        clear();
        rx_en_i = 1'b0;
        status("clr_prio");
        frame_err_i = 1'b1; parity_err_i = 1'b1; tick();
        frame_err_i = 1'b0; parity_err_i = 1'b0;
        status("err_nopush");

        // Reset mid-burst discards contents
        push(8'h71); push(8'h72); push(8'h73);
        do_reset("reset_mid");
        push(8'h5A);
        status("post_reset");
        pop("post_reset_rd");

        // Threshold 0 behaves as 1
        thresh_i = 4'd0;
        push(8'h99);
        status("thr0");
        pop("thr0_rd");

`ifdef UART_RX_ERRCNT_EN
        frame_err_i = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        frame_err_i = 1'b0;
        chk("ferr.sat", 32'(ferr_cnt_o), 32'd255);
        chk("perr.idle", 32'(perr_cnt_o), 32'd0);
        resetn = 1'b0; tick(); resetn = 1'b1;
        chk("ferr.reset", 32'(ferr_cnt_o), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4: receive FIFO depth is 2**DEPTH_LOG2 entries.
REQ-002 SHALL have port clk, input, 1: single system clock (48 MHz); all logic is on its rising edge.
REQ-003 SHALL have port resetn, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port divisor_i, input, 12: 16x-baud prescaler reload value; tick period is divisor_i+1 clk.
REQ-005 SHALL have port uart_cken_o, output, 1: 1T pulse at 16x baud, driven to the RX deserializer.
REQ-006 SHALL have port rx_byte_i, input, 8: received byte from the deserializer.
REQ-007 SHALL have port rx_en_i, input, 1: 1T strobe, rx_byte_i valid.
REQ-008 SHALL have port frame_err_i, input, 1: 1T framing-error strobe.
REQ-009 SHALL have port parity_err_i, input, 1: 1T parity-error strobe.
REQ-010 SHALL have port rd_i, input, 1: 1T pop request from the CPU-side register file.
REQ-011 SHALL have port rd_data_o, output, 8: FIFO head byte (first-word fall-through).
REQ-012 SHALL have port empty_o, output, 1: FIFO empty; full_o, output, 1: FIFO full.
REQ-013 SHALL have port count_o, output, DEPTH_LOG2+1: current FIFO occupancy.
REQ-014 SHALL have port thresh_i, input, DEPTH_LOG2: IRQ fill threshold.
REQ-015 SHALL have port clr_i, input, 1: 1T flush of FIFO and sticky status.
REQ-016 SHALL have port overrun_o, output, 1: sticky, byte dropped because FIFO full.
REQ-017 SHALL have port irq_o, output, 1: level interrupt request.

Function
REQ-018 Prescaler SHALL be a down-counter: at 0, assert uart_cken_o for one clk and reload divisor_i; else decrement; divisor_i=0 gives uart_cken_o every clk.
REQ-019 A divisor_i change SHALL take effect only at the next reload; no glitch or extra pulse is permitted.
REQ-020 rx_en_i=1 with FIFO not full SHALL write rx_byte_i at the tail; count_o increments on the next clk.
REQ-021 rx_en_i=1 with FIFO full and rd_i=0 SHALL drop the byte, set overrun_o, and leave FIFO contents unchanged.
REQ-022 rx_en_i=1 and rd_i=1 in the same clk with FIFO full SHALL pop and push; count_o stays at 2**DEPTH_LOG2 and overrun_o is not set.
REQ-023 rd_i=1 with FIFO non-empty SHALL advance the head; rd_data_o shows the next byte on the following clk.
REQ-024 rd_i=1 while empty SHALL be ignored, with no pointer or count change.
REQ-025 rd_i=1 and rx_en_i=1 while empty SHALL perform the push only.
REQ-026 Read/write pointers SHALL be DEPTH_LOG2 bits and wrap modulo depth.
REQ-027 empty_o SHALL equal (count_o==0); full_o SHALL equal (count_o==2**DEPTH_LOG2); both are derived from registered count.
REQ-028 irq_o SHALL equal overrun_o OR (count_o >= max(thresh_i,1)).
REQ-029 rd_data_o SHALL be undefined-but-stable when empty_o=1; the bench must not check it then.
REQ-030 clr_i SHALL zero pointers, count, overrun_o and (if compiled) error counters on the next clk; clr_i has priority over a simultaneous push/pop; prescaler is unaffected.
REQ-031 frame_err_i/parity_err_i SHALL never push data.

Reset
REQ-032 While resetn=0, on clk edge: prescaler=0, uart_cken_o=0, pointers=0, count_o=0, empty_o=1, full_o=0, overrun_o=0, irq_o=0, error counters=0.
REQ-033 Reset asserted mid-byte or mid-burst SHALL discard all FIFO contents; first push after release lands at entry 0.

Configuration
REQ-034 Macro UART_RX_ERRCNT_EN defined SHALL add outputs ferr_cnt_o[7:0] and perr_cnt_o[7:0], incremented on frame_err_i/parity_err_i, saturating at 255, cleared by clr_i/reset.
REQ-035 Macro UART_RX_ERRCNT_EN undefined SHALL omit those ports and counters entirely; all other behaviour is identical.

Verification
REQ-036 divisor_i=2 -> uart_cken_o pulses every 3rd clk; change to 5 mid-count -> first 6-clk period starts after the current reload.
REQ-037 Push 0x11,0x22,0x33, then rd_i x3 -> rd_data_o shows 0x11,0x22,0x33 in order; empty_o=1 at end.
REQ-038 DEPTH_LOG2=4: push 17 bytes without reads -> count_o=16, full_o=1, overrun_o=1, 17th byte absent; clr_i -> count_o=0, overrun_o=0.
REQ-039 Full FIFO with simultaneous rx_en_i and rd_i -> count_o stays 16, overrun_o=0, new byte read last.
REQ-040 thresh_i=4: pushes 1..3 -> irq_o=0; 4th push -> irq_o=1 next clk; one rd_i -> irq_o=0.
REQ-041 With UART_RX_ERRCNT_EN: 300 frame_err_i strobes -> ferr_cnt_o=255; resetn=0 for one clk -> 0.
